bins_frame_parser: RTL and testbench
====================================

BINS_FRAME_PARSER -- requirements
Module: bins_frame_parser

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 20000, maximum inter-byte gap in clockIN cycles.
REQ-004 SHALL have port clockIN, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port nRxResetIN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rxReadyIN, input, 1, byte-ready level from the UART receiver, asynchronous to clockIN.
REQ-007 SHALL have port rxDataIN, input, 8, received byte, stable while rxReadyIN is high.
REQ-008 SHALL have port outValidOUT, output, 1, payload byte valid.
REQ-009 SHALL have port outReadyIN, input, 1, downstream accepts the byte.
REQ-010 SHALL have port outDataOUT, output, 8, payload byte.
REQ-011 SHALL have port outLastOUT, output, 1, final payload byte of the frame.
REQ-012 SHALL have port outIdOUT, output, 8, frame ID, held stable for the whole drain.
REQ-013 SHALL have ports csumErrOUT, lenErrOUT, timeoutErrOUT and overrunErrOUT, each output, 1, single-cycle error pulses.

Function
REQ-014 SHALL synchronise rxReadyIN through two flops, detect its rising edge and capture rxDataIN on the detect cycle ("byte event"), 3 cycles after the input edge.
REQ-015 SHALL use frame format 0xAA, 0x55, ID, LEN, LEN payload bytes, CSUM; CSUM = (ID + LEN + sum of payload) mod 256.
REQ-016 SHALL implement FSM states HUNT_AA, HUNT_55, ID, LEN, PAYLOAD, CSUM and DRAIN, advancing only on byte events except in DRAIN.
REQ-017 HUNT_AA: 0xAA -> HUNT_55; any other byte -> stay in HUNT_AA.
REQ-018 HUNT_55: 0x55 -> ID; 0xAA -> stay in HUNT_55; any other byte -> HUNT_AA.
REQ-019 ID: store the byte as ID -> LEN; LEN: 1..MAX_LEN -> PAYLOAD; 0 or >MAX_LEN -> lenErrOUT pulse and HUNT_AA.
REQ-020 PAYLOAD: write the byte to buffer[index], index+1; after the LEN-th byte -> CSUM.
REQ-021 CSUM: on match -> DRAIN; on mismatch -> csumErrOUT pulse, HUNT_AA, and no output.
REQ-022 Checksum accumulator SHALL be 8 bits wide, wrap modulo 256, and clear on entry to ID.
REQ-023 DRAIN: outValidOUT SHALL be high the cycle after the CSUM byte event, with outDataOUT = buffer[0] and outIdOUT = ID.
REQ-024 DRAIN: on outValidOUT & outReadyIN advance to the next byte; outLastOUT high only with byte LEN-1; after that byte is accepted, outValidOUT low next cycle and -> HUNT_AA.
REQ-025 outValidOUT, outDataOUT and outLastOUT SHALL remain stable while outReadyIN is low; the FSM SHALL wait indefinitely.
REQ-026 Byte events during DRAIN SHALL be discarded, each with one overrunErrOUT pulse.
REQ-027 Gap counter SHALL clear on every byte event; in states HUNT_55 through CSUM, reaching TIMEOUT_CLKS -> timeoutErrOUT pulse and HUNT_AA; inactive in HUNT_AA and DRAIN.
REQ-028 A byte event coinciding with timeout SHALL be processed in HUNT_AA context (timeout wins).
REQ-029 Error pulses SHALL be mutually exclusive per cycle and registered.

Reset
REQ-030 SHALL, on nRxResetIN low: state HUNT_AA, counters 0, sync flops 0, all outputs 0, regardless of the current state, including mid-frame and mid-drain.
REQ-031 SHALL leave the buffer contents unreset; the buffer SHALL never be observable before being written.
REQ-032 SHALL treat rxReadyIN high at reset release as no edge; the first byte event requires a low-to-high transition.

Structure
REQ-033 Package bins_frame_pkg SHALL hold the state enum, SYNC1 = 0xAA, SYNC2 = 0x55 and the MAX_LEN default.
REQ-034 Sub-module bins_byte_sync SHALL contain the synchroniser, edge detect and data capture; the buffer SHALL be a MAX_LEN x 8 register array or inferred RAM with registered read.

Verification
REQ-035 Frame AA 55 01 03 10 20 30 64 with outReadyIN=1 -> outIdOUT=01; 10, 20, 30 on consecutive cycles, outLastOUT with 30; no errors.
REQ-036 Same frame with CSUM 65 -> csumErrOUT one pulse, outValidOUT never high; next good frame is delivered.
REQ-037 AA 55 02 00 -> lenErrOUT pulse; AA 55 02 21 (MAX_LEN=32) -> lenErrOUT pulse; FSM in HUNT_AA.
REQ-038 AA 55 01, then a gap of TIMEOUT_CLKS -> timeoutErrOUT pulse; then AA AA 55 01 01 7F 81 -> byte 7F delivered with outLastOUT.
REQ-039 Good frame with outReadyIN low for 50 cycles and one byte event during the drain -> output held stable, one overrunErrOUT pulse, all bytes delivered.
REQ-040 Reset asserted while in PAYLOAD and while in DRAIN -> all outputs 0 immediately; subsequent full frame parsed correctly.

Source files
------------

// File: rtl/bins_frame_pkg.sv
// Shared definitions for the BINS serial frame parser: parser states,
// sync bytes and the default payload capacity.
package bins_frame_pkg;

    typedef enum logic [2:0] {
        HUNT_AA,
        HUNT_55,
        ID,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } parserState_t;

    localparam logic [7:0] SYNC1 = 8'hAA;
    localparam logic [7:0] SYNC2 = 8'h55;
    localparam int MAX_LEN_DEFAULT = 32;

endpackage

// File: rtl/bins_frame_parser_if.sv
// Payload output stream of the frame parser: valid/ready handshake plus
// data, end-of-frame marker and the frame ID.
interface bins_frame_parser_if;
    logic       outValidOUT;
    logic       outReadyIN;
    logic [7:0] outDataOUT;
    logic       outLastOUT;
    logic [7:0] outIdOUT;

    modport master (
        output outValidOUT,
        output outDataOUT,
        output outLastOUT,
        output outIdOUT,
        input  outReadyIN
    );

    modport slave (
        input  outValidOUT,
        input  outDataOUT,
        input  outLastOUT,
        input  outIdOUT,
        output outReadyIN
    );
endinterface

// File: rtl/bins_byte_sync.sv
// Brings the UART byte-ready level into the clockIN domain and turns each
// rising edge into a one-cycle byte event with the data captured alongside.
module bins_byte_sync (
    input  logic       clockIN,
    input  logic       nRxResetIN,
    input  logic       rxReadyIN,
    input  logic [7:0] rxDataIN,
    output logic       byteEventOUT,
    output logic [7:0] byteDataOUT
);
    logic       sync1Reg;
    logic       sync2Reg;
    logic       sync3Reg;
    logic [1:0] fillReg;
    logic       armedReg;
    logic       edgeSeen;

    // Edges only count once the synchroniser has shown a real low level,
    // so a ready line already high at reset release is not taken as a byte.
    assign edgeSeen = armedReg & sync2Reg & ~sync3Reg;

    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            sync1Reg     <= 1'b0;
            sync2Reg     <= 1'b0;
            sync3Reg     <= 1'b0;
            fillReg      <= 2'b00;
            armedReg     <= 1'b0;
            byteEventOUT <= 1'b0;
            byteDataOUT  <= 8'h00;
        end else begin
            sync1Reg     <= rxReadyIN;
            sync2Reg     <= sync1Reg;
            sync3Reg     <= sync2Reg;
            fillReg      <= {fillReg[0], 1'b1};
            armedReg     <= armedReg | (fillReg[1] & ~sync2Reg);
            byteEventOUT <= edgeSeen;
            if (edgeSeen) begin
                byteDataOUT <= rxDataIN;
            end
        end
    end
endmodule

// File: rtl/bins_frame_parser.sv
// BINS frame parser: hunts AA 55, collects ID/LEN/payload, verifies the
// 8-bit additive checksum and drains the buffered payload over outIf.
module bins_frame_parser
    import bins_frame_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int MAX_LEN         = MAX_LEN_DEFAULT,
    parameter int TIMEOUT_CLKS    = 20000
) (
    input  logic                       clockIN,
    input  logic                       nRxResetIN,
    input  logic                       rxReadyIN,
    input  logic [7:0]                 rxDataIN,
    bins_frame_parser_if.master        outIf,
    output logic                       csumErrOUT,
    output logic                       lenErrOUT,
    output logic                       timeoutErrOUT,
    output logic                       overrunErrOUT
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [8:0]       MAX_LEN9  = 9'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_ONE   = 1;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = 1;

    if (CLOCK_FREQUENCY <= 0) begin : gBadClock
        $error("bins_frame_parser: CLOCK_FREQUENCY must be positive");
    end

    logic       byteEvent;
    logic [7:0] byteData;

    bins_byte_sync uSync (
        .clockIN      (clockIN),
        .nRxResetIN   (nRxResetIN),
        .rxReadyIN    (rxReadyIN),
        .rxDataIN     (rxDataIN),
        .byteEventOUT (byteEvent),
        .byteDataOUT  (byteData)
    );

    parserState_t     stateReg, stateNext, ctx;
    logic [7:0]       idReg, idNext;
    logic [7:0]       csumReg, csumNext;
    logic [IDX_W-1:0] idxReg, idxNext;
    logic [IDX_W-1:0] lastIdxReg, lastIdxNext;
    logic [GAP_W-1:0] gapReg, gapNext;
    logic             outValidReg, outValidNext;
    logic             outLastReg, outLastNext;
    logic [7:0]       outDataReg, outDataNext;
    logic             csumErrNext, lenErrNext, timeoutErrNext, overrunErrNext;
    logic             bufWrite;
    logic             active;
    logic             timeoutHit;
    logic [7:0]       lenM1;
    logic [7:0]       buffer [MAX_LEN];

    always_comb begin
        stateNext      = stateReg;
        idNext         = idReg;
        csumNext       = csumReg;
        idxNext        = idxReg;
        lastIdxNext    = lastIdxReg;
        outValidNext   = outValidReg;
        outLastNext    = outLastReg;
        outDataNext    = outDataReg;
        csumErrNext    = 1'b0;
        lenErrNext     = 1'b0;
        timeoutErrNext = 1'b0;
        overrunErrNext = 1'b0;
        bufWrite       = 1'b0;
        lenM1          = byteData - 8'd1;
        active         = stateReg inside {HUNT_55, ID, LEN, PAYLOAD, CSUM};
        timeoutHit     = active && (gapReg == GAP_LIMIT);
        gapNext        = (byteEvent || !active) ? '0 : gapReg + GAP_ONE;
        ctx            = stateReg;

        // A byte landing on the timeout cycle is re-read as a fresh hunt byte.
        if (timeoutHit) begin
            timeoutErrNext = 1'b1;
            stateNext      = HUNT_AA;
            gapNext        = '0;
            ctx            = HUNT_AA;
        end

        case (ctx)
            HUNT_AA: begin
                if (byteEvent && byteData == SYNC1) stateNext = HUNT_55;
            end
            HUNT_55: begin
                if (byteEvent) begin
                    if (byteData == SYNC2) begin
                        stateNext = ID;
                        csumNext  = 8'h00;
                    end else if (byteData != SYNC1) begin
                        stateNext = HUNT_AA;
                    end
                end
            end
            ID: begin
                if (byteEvent) begin
                    idNext    = byteData;
                    csumNext  = csumReg + byteData;
                    stateNext = LEN;
                end
            end
            LEN: begin
                if (byteEvent) begin
                    if (byteData == 8'h00 || {1'b0, byteData} > MAX_LEN9) begin
                        lenErrNext = 1'b1;
                        stateNext  = HUNT_AA;
                    end else begin
                        lastIdxNext = lenM1[IDX_W-1:0];
                        idxNext     = '0;
                        csumNext    = csumReg + byteData;
                        stateNext   = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byteEvent) begin
                    bufWrite = 1'b1;
                    csumNext = csumReg + byteData;
                    idxNext  = idxReg + IDX_ONE;
                    if (idxReg == lastIdxReg) stateNext = CSUM;
                end
            end
            CSUM: begin
                if (byteEvent) begin
                    if (byteData == csumReg) begin
                        stateNext    = DRAIN;
                        outValidNext = 1'b1;
                        outDataNext  = buffer[0];
                        outLastNext  = (lastIdxReg == '0);
                        idxNext      = IDX_ONE;
                    end else begin
                        csumErrNext = 1'b1;
                        stateNext   = HUNT_AA;
                    end
                end
            end
            DRAIN: begin
                overrunErrNext = byteEvent;
                if (outValidReg && outIf.outReadyIN) begin
                    if (outLastReg) begin
                        outValidNext = 1'b0;
                        outLastNext  = 1'b0;
                        stateNext    = HUNT_AA;
                    end else begin
                        outDataNext = buffer[idxReg];
                        outLastNext = (idxReg == lastIdxReg);
                        idxNext     = idxReg + IDX_ONE;
                    end
                end
            end
            default: stateNext = HUNT_AA;
        endcase
    end

    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            stateReg      <= HUNT_AA;
            idReg         <= 8'h00;
            csumReg       <= 8'h00;
            idxReg        <= '0;
            lastIdxReg    <= '0;
            gapReg        <= '0;
            outValidReg   <= 1'b0;
            outLastReg    <= 1'b0;
            outDataReg    <= 8'h00;
            csumErrOUT    <= 1'b0;
            lenErrOUT     <= 1'b0;
            timeoutErrOUT <= 1'b0;
            overrunErrOUT <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            idReg         <= idNext;
            csumReg       <= csumNext;
            idxReg        <= idxNext;
            lastIdxReg    <= lastIdxNext;
            gapReg        <= gapNext;
            outValidReg   <= outValidNext;
            outLastReg    <= outLastNext;
            outDataReg    <= outDataNext;
            csumErrOUT    <= csumErrNext;
            lenErrOUT     <= lenErrNext;
            timeoutErrOUT <= timeoutErrNext;
            overrunErrOUT <= overrunErrNext;
        end
    end

    // Payload store is left unreset so it can map onto distributed/block RAM.
    always_ff @(posedge clockIN) begin
        if (bufWrite) begin
            buffer[idxReg] <= byteData;
        end
    end

    assign outIf.outValidOUT = outValidReg;
    assign outIf.outDataOUT  = outDataReg;
    assign outIf.outLastOUT  = outLastReg;
    assign outIf.outIdOUT    = idReg;
endmodule

// File: tb/tb_bins_frame_parser.sv
// Directed bench for bins_frame_parser: good/bad frames, length and timeout
// errors, back-pressure with overrun, and reset mid-frame / mid-drain.
module tb_bins_frame_parser;
    localparam int TO_CLKS = 200;

    logic       clockIN = 1'b0;
    logic       nRxResetIN;
    logic       rxReadyIN;
    logic [7:0] rxDataIN;
    logic       csumErrOUT, lenErrOUT, timeoutErrOUT, overrunErrOUT;

    bins_frame_parser_if outIf ();

    bins_frame_parser #(
        .CLOCK_FREQUENCY (50_000_000),
        .MAX_LEN         (32),
        .TIMEOUT_CLKS    (TO_CLKS)
    ) dut (
        .clockIN       (clockIN),
        .nRxResetIN    (nRxResetIN),
        .rxReadyIN     (rxReadyIN),
        .rxDataIN      (rxDataIN),
        .outIf         (outIf),
        .csumErrOUT    (csumErrOUT),
        .lenErrOUT     (lenErrOUT),
        .timeoutErrOUT (timeoutErrOUT),
        .overrunErrOUT (overrunErrOUT)
    );

    always #5 clockIN = ~clockIN;

    int errors = 0;
    int checks = 0;

    // Monitor: cumulative pulse counts and a log of accepted output bytes.
    int csCnt = 0, lenCnt = 0, toCnt = 0, ovCnt = 0, validCnt = 0, cyc = 0;
    int gotN = 0;
    logic [7:0] gotData [256];
    logic       gotLast [256];
    logic [7:0] gotId   [256];
    int         gotCyc  [256];

    always @(negedge clockIN) begin
        if (csumErrOUT)    csCnt++;
        if (lenErrOUT)     lenCnt++;
        if (timeoutErrOUT) toCnt++;
        if (overrunErrOUT) ovCnt++;
        if (outIf.outValidOUT) validCnt++;
        if (outIf.outValidOUT && outIf.outReadyIN && gotN < 256) begin
            gotData[gotN] = outIf.outDataOUT;
            gotLast[gotN] = outIf.outLastOUT;
            gotId[gotN]   = outIf.outIdOUT;
            gotCyc[gotN]  = cyc;
            gotN++;
        end
        cyc++;
    end

    int bCs, bLen, bTo, bOv, bV, bN;
    logic [7:0] frm [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        bCs = csCnt; bLen = lenCnt; bTo = toCnt; bOv = ovCnt; bV = validCnt; bN = gotN;
    endtask

    task automatic checkErrs(input string tag, input int cs, input int ln, input int to, input int ov);
        check({tag, "_csumErr"},    csCnt - bCs,   cs);
        check({tag, "_lenErr"},     lenCnt - bLen, ln);
        check({tag, "_timeoutErr"}, toCnt - bTo,   to);
        check({tag, "_overrunErr"}, ovCnt - bOv,   ov);
    endtask

    task automatic checkByte(input string tag, input int k, input logic [7:0] d,
                             input logic l, input logic [7:0] id);
        check({tag, "_data"}, gotData[bN + k], d);
        check({tag, "_last"}, gotLast[bN + k], l);
        check({tag, "_id"},   gotId[bN + k],   id);
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxDataIN  = b;
        rxReadyIN = 1'b1;
        repeat (4) @(negedge clockIN);
        rxReadyIN = 1'b0;
        repeat (4) @(negedge clockIN);
    endtask

    task automatic sendBytes(input logic [7:0] q [$]);
        foreach (q[i]) sendByte(q[i]);
    endtask

    task automatic setReady(input logic r);
        @(posedge clockIN);
        #1 outIf.outReadyIN = r;
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_valid"}, outIf.outValidOUT, 1'b0);
        check({tag, "_data"},  outIf.outDataOUT,  8'h00);
        check({tag, "_last"},  outIf.outLastOUT,  1'b0);
        check({tag, "_id"},    outIf.outIdOUT,    8'h00);
        check({tag, "_errs"},  {csumErrOUT, lenErrOUT, timeoutErrOUT, overrunErrOUT}, 4'b0000);
    endtask

    int stableBad;

    initial begin
        nRxResetIN        = 1'b0;
        rxReadyIN         = 1'b1;
        rxDataIN          = 8'hAA;
        outIf.outReadyIN  = 1'b1;
        repeat (3) @(negedge clockIN);
        checkOutputsZero("reset");

        // Ready already high at release must not produce a byte event.
        nRxResetIN = 1'b1;
        repeat (10) @(negedge clockIN);
        rxReadyIN = 1'b0;
        repeat (6) @(negedge clockIN);
        snap();
        frm = '{8'h55, 8'h01, 8'h01, 8'h7F, 8'h81};
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("no_edge_at_release_bytes", gotN - bN, 0);
        check("no_edge_at_release_valid", validCnt - bV, 0);

        // Basic good frame, ready held high.
        snap();
        frm = '{8'hAA, 8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("good_count", gotN - bN, 3);
        checkByte("good_b0", 0, 8'h10, 1'b0, 8'h01);
        checkByte("good_b1", 1, 8'h20, 1'b0, 8'h01);
        checkByte("good_b2", 2, 8'h30, 1'b1, 8'h01);
        check("good_consecutive", gotCyc[bN + 2] - gotCyc[bN], 2);
        checkErrs("good", 0, 0, 0, 0);

        // Bad checksum, then recovery on the next frame.
        snap();
        frm = '{8'hAA, 8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65};
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("badcsum_valid_cycles", validCnt - bV, 0);
        checkErrs("badcsum", 1, 0, 0, 0);
        snap();
        frm = '{8'hAA, 8'h55, 8'h02, 8'h02, 8'hAB, 8'hCD, 8'h7C};
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("recover_count", gotN - bN, 2);
        checkByte("recover_b0", 0, 8'hAB, 1'b0, 8'h02);
        checkByte("recover_b1", 1, 8'hCD, 1'b1, 8'h02);

        // Length 0 and length MAX_LEN+1 rejected.
        snap();
        frm = '{8'hAA, 8'h55, 8'h02, 8'h00};
        sendBytes(frm);
        repeat (3) @(negedge clockIN);
        checkErrs("len0", 0, 1, 0, 0);
        snap();
        frm = '{8'hAA, 8'h55, 8'h02, 8'h21};
        sendBytes(frm);
        repeat (3) @(negedge clockIN);
        checkErrs("len33", 0, 1, 0, 0);

        // Inter-byte gap timeout, then a frame with a repeated AA.
        snap();
        frm = '{8'hAA, 8'h55, 8'h01};
        sendBytes(frm);
        repeat (TO_CLKS + 20) @(negedge clockIN);
        checkErrs("timeout", 0, 0, 1, 0);
        snap();
        frm = '{8'hAA, 8'hAA, 8'h55, 8'h01, 8'h01, 8'h7F, 8'h81};
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("after_timeout_count", gotN - bN, 1);
        checkByte("after_timeout_b0", 0, 8'h7F, 1'b1, 8'h01);
        checkErrs("after_timeout", 0, 0, 0, 0);

        // Back-pressure for 50 cycles with one overrun byte mid-drain.
        snap();
        setReady(1'b0);
        frm = '{8'hAA, 8'h55, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38};
        sendBytes(frm);
        stableBad = 0;
        for (int i = 0; i < 42; i++) begin
            if (i == 10) sendByte(8'h5A);
            if (outIf.outValidOUT !== 1'b1 || outIf.outDataOUT !== 8'h11 ||
                outIf.outLastOUT !== 1'b0 || outIf.outIdOUT !== 8'h03) stableBad++;
            @(negedge clockIN);
        end
        check("stall_stable_violations", stableBad, 0);
        check("stall_nothing_accepted", gotN - bN, 0);
        setReady(1'b1);
        repeat (6) @(negedge clockIN);
        check("stall_count", gotN - bN, 2);
        checkByte("stall_b0", 0, 8'h11, 1'b0, 8'h03);
        checkByte("stall_b1", 1, 8'h22, 1'b1, 8'h03);
        checkErrs("stall", 0, 0, 0, 1);

        // Reset while collecting payload.
        frm = '{8'hAA, 8'h55, 8'h01, 8'h03, 8'h10};
        sendBytes(frm);
        check("pre_reset_payload_id", outIf.outIdOUT, 8'h01);
        #2 nRxResetIN = 1'b0;
        #1 checkOutputsZero("reset_payload");
        repeat (2) @(negedge clockIN);
        nRxResetIN = 1'b1;
        repeat (5) @(negedge clockIN);

        // Reset while a stalled drain is pending.
        setReady(1'b0);
        frm = '{8'hAA, 8'h55, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        sendBytes(frm);
        check("pre_reset_drain_valid", outIf.outValidOUT, 1'b1);
        #2 nRxResetIN = 1'b0;
        #1 checkOutputsZero("reset_drain");
        repeat (2) @(negedge clockIN);
        nRxResetIN = 1'b1;
        setReady(1'b1);
        repeat (5) @(negedge clockIN);
        snap();
        sendBytes(frm);
        repeat (5) @(negedge clockIN);
        check("post_reset_count", gotN - bN, 3);
        checkByte("post_reset_b0", 0, 8'h10, 1'b0, 8'h01);
        checkByte("post_reset_b2", 2, 8'h30, 1'b1, 8'h01);
        checkErrs("post_reset", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
